// File: rtl/icache_linefill_ctrl.sv
// Instruction-cache linefill controller: assembles refill beats into a line, writes it to the
// data RAM and pulses the owning MSHR entry's per-line done bit. Option: ICACHE_LINEFILL_ORDER_CHK_EN.
module icache_linefill_ctrl #(
  parameter int unsigned MSHR_ENTRY_NUM = 8,
  parameter int unsigned WAY_NUM        = 4,
  parameter int unsigned INDEX_WIDTH    = 7,
  parameter int unsigned BEAT_NUM       = 4,
  parameter int unsigned BEAT_WIDTH     = 128,
  localparam int unsigned TxnW  = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1,
  localparam int unsigned BeatW = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1,
  localparam int unsigned LineW = BEAT_NUM * BEAT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxdat_vld_i,
  output logic                      rxdat_rdy_o,
  input  logic [BEAT_WIDTH-1:0]     rxdat_data_i,
  input  logic [TxnW-1:0]           rxdat_txnid_i,
  input  logic                      rxdat_lineA_i,
  input  logic [BeatW-1:0]          rxdat_beat_id_i,
  output logic [TxnW-1:0]           lkup_txnid_o,
  output logic                      lkup_lineA_o,
  input  logic [WAY_NUM-1:0]        lkup_way_i,
  input  logic [INDEX_WIDTH-1:0]    lkup_index_i,
  output logic                      dataram_wr_vld_o,
  input  logic                      dataram_wr_rdy_i,
  output logic [WAY_NUM-1:0]        dataram_wr_way_o,
  output logic [INDEX_WIDTH-1:0]    dataram_wr_index_o,
  output logic [LineW-1:0]          dataram_wr_data_o,
  output logic [MSHR_ENTRY_NUM-1:0] v_linefillA_done_o,
  output logic [MSHR_ENTRY_NUM-1:0] v_linefillB_done_o,
  output logic                      linefill_err_o
);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e                    state_q, state_d;
  logic [BeatW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [TxnW-1:0]           txnid_q, txnid_d;
  logic                      linea_q, linea_d;
  logic [WAY_NUM-1:0]        way_q, way_d;
  logic [INDEX_WIDTH-1:0]    index_q, index_d;
  logic [LineW-1:0]          line_q, line_d;
  logic                      wr_vld_q, wr_vld_d;
  logic [MSHR_ENTRY_NUM-1:0] done_a_q, done_a_d;
  logic [MSHR_ENTRY_NUM-1:0] done_b_q, done_b_d;
  logic                      accept;
  logic                      beat_last;

  assign lkup_txnid_o = rxdat_txnid_i;
  assign lkup_lineA_o = rxdat_lineA_i;
  assign rxdat_rdy_o  = (state_q == StIdle) || (state_q == StCollect);
  assign accept       = rxdat_vld_i && rxdat_rdy_o;
  assign beat_last    = (beat_cnt_q == BeatW'(BEAT_NUM - 1));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    txnid_d    = txnid_q;
    linea_d    = linea_q;
    way_d      = way_q;
    index_d    = index_q;
    line_d     = line_q;
    done_a_d   = '0;
    done_b_d   = '0;

    if (accept) begin
      for (int k = 0; k < int'(BEAT_NUM); k++) begin
        if (beat_cnt_q == BeatW'(k)) line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = rxdat_data_i;
      end
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          // Destination is sampled only on the first beat of a line.
          txnid_d = rxdat_txnid_i;
          linea_d = rxdat_lineA_i;
          way_d   = lkup_way_i;
          index_d = lkup_index_i;
          state_d = (BEAT_NUM == 1) ? StWrite : StCollect;
        end
      end
      StCollect: begin
        if (accept && beat_last) state_d = StWrite;
      end
      StWrite: begin
        if (dataram_wr_rdy_i) begin
          state_d = StDone;
          if (linea_q) done_a_d[txnid_q] = 1'b1;
          else         done_b_d[txnid_q] = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    wr_vld_d = (state_d == StWrite);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      txnid_q    <= '0;
      linea_q    <= 1'b0;
      way_q      <= '0;
      index_q    <= '0;
      line_q     <= '0;
      wr_vld_q   <= 1'b0;
      done_a_q   <= '0;
      done_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      txnid_q    <= txnid_d;
      linea_q    <= linea_d;
      way_q      <= way_d;
      index_q    <= index_d;
      line_q     <= line_d;
      wr_vld_q   <= wr_vld_d;
      done_a_q   <= done_a_d;
      done_b_q   <= done_b_d;
    end
  end

  assign dataram_wr_vld_o   = wr_vld_q;
  assign dataram_wr_way_o   = way_q;
  assign dataram_wr_index_o = index_q;
  assign dataram_wr_data_o  = line_q;
  assign v_linefillA_done_o = done_a_q;
  assign v_linefillB_done_o = done_b_q;

`ifdef ICACHE_LINEFILL_ORDER_CHK_EN
  logic err_q, err_d;

  // Out-of-order beats are still stored by arrival slot; only the sticky flag records it.
  assign err_d = err_q | (accept && (rxdat_beat_id_i != beat_cnt_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign linefill_err_o = err_q;
`else
  logic unused_beat_id;
  assign unused_beat_id = ^rxdat_beat_id_i;
  assign linefill_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed self-checking bench for icache_linefill_ctrl (default parameters).
module tb_icache_linefill_ctrl;

  logic         clk;
  logic         rst;
  logic         rxdat_vld;
  logic         rxdat_rdy;
  logic [127:0] rxdat_data;
  logic [2:0]   rxdat_txnid;
  logic         rxdat_lineA;
  logic [1:0]   rxdat_beat_id;
  logic [2:0]   lkup_txnid;
  logic         lkup_lineA;
  logic [3:0]   lkup_way;
  logic [6:0]   lkup_index;
  logic         wr_vld;
  logic         wr_rdy;
  logic [3:0]   wr_way;
  logic [6:0]   wr_index;
  logic [511:0] wr_data;
  logic [7:0]   done_a;
  logic [7:0]   done_b;
  logic         err;

  int passed = 0;
  int total  = 0;

`ifdef ICACHE_LINEFILL_ORDER_CHK_EN
  localparam bit OrderChk = 1'b1;
`else
  localparam bit OrderChk = 1'b0;
`endif

  icache_linefill_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .rxdat_vld_i        (rxdat_vld),
    .rxdat_rdy_o        (rxdat_rdy),
    .rxdat_data_i       (rxdat_data),
    .rxdat_txnid_i      (rxdat_txnid),
    .rxdat_lineA_i      (rxdat_lineA),
    .rxdat_beat_id_i    (rxdat_beat_id),
    .lkup_txnid_o       (lkup_txnid),
    .lkup_lineA_o       (lkup_lineA),
    .lkup_way_i         (lkup_way),
    .lkup_index_i       (lkup_index),
    .dataram_wr_vld_o   (wr_vld),
    .dataram_wr_rdy_i   (wr_rdy),
    .dataram_wr_way_o   (wr_way),
    .dataram_wr_index_o (wr_index),
    .dataram_wr_data_o  (wr_data),
    .v_linefillA_done_o (done_a),
    .v_linefillB_done_o (done_b),
    .linefill_err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] bt(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic feed(input logic [7:0] b, input logic [1:0] id);
    rxdat_vld     = 1'b1;
    rxdat_data    = bt(b);
    rxdat_beat_id = id;
    tick();
  endtask

  task automatic chk_write(input string tag, input logic [3:0] way, input logic [6:0] idx,
                           input logic [511:0] data);
    chk({tag, "_vld"}, 512'(wr_vld), 512'(1'b1));
    chk({tag, "_way"}, 512'(wr_way), 512'(way));
    chk({tag, "_idx"}, 512'(wr_index), 512'(idx));
    chk({tag, "_data"}, wr_data, data);
    chk({tag, "_rdy0"}, 512'(rxdat_rdy), 512'(1'b0));
  endtask

  task automatic chk_done(input string tag, input logic [7:0] a, input logic [7:0] b);
    chk({tag, "_doneA"}, 512'(done_a), 512'(a));
    chk({tag, "_doneB"}, 512'(done_b), 512'(b));
    chk({tag, "_novld"}, 512'(wr_vld), 512'(1'b0));
  endtask

  initial begin
    rst = 1'b1; rxdat_vld = 1'b0; rxdat_data = '0; rxdat_txnid = '0; rxdat_lineA = 1'b0;
    rxdat_beat_id = '0; lkup_way = '0; lkup_index = '0; wr_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_rdy", 512'(rxdat_rdy), 512'(1'b1));
    chk("rst_vld", 512'(wr_vld), 512'(1'b0));
    chk("rst_done", 512'({done_a, done_b}), 512'(16'h0));
    chk("rst_err", 512'(err), 512'(1'b0));
    chk("rst_data", wr_data, 512'h0);

    // Single line A, entry 3.
    rxdat_txnid = 3'd3; rxdat_lineA = 1'b1; lkup_way = 4'b0100; lkup_index = 7'h2A;
    chk("lkup_txnid", 512'(lkup_txnid), 512'(3'd3));
    chk("lkup_lineA", 512'(lkup_lineA), 512'(1'b1));
    feed(8'h11, 2'd0);
    chk("t1_collect_vld", 512'(wr_vld), 512'(1'b0));
    feed(8'h22, 2'd1); feed(8'h33, 2'd2);
    chk("t1_pre_vld", 512'(wr_vld), 512'(1'b0));
    feed(8'h44, 2'd3);
    rxdat_vld = 1'b0;
    chk_write("t1", 4'b0100, 7'h2A, {bt(8'h44), bt(8'h33), bt(8'h22), bt(8'h11)});
    chk("t1_wdone", 512'({done_a, done_b}), 512'(16'h0));
    tick();
    chk_done("t1", 8'b0000_1000, 8'h00);
    tick();
    chk_done("t1_idle", 8'h00, 8'h00);
    chk("t1_idle_rdy", 512'(rxdat_rdy), 512'(1'b1));

    // Backpressure, entry 1 line B; a beat offered during WRITE must be ignored.
    wr_rdy = 1'b0; rxdat_txnid = 3'd1; rxdat_lineA = 1'b0; lkup_way = 4'b0001; lkup_index = 7'h10;
    feed(8'h55, 2'd0); feed(8'h66, 2'd1); feed(8'h77, 2'd2); feed(8'h88, 2'd3);
    rxdat_vld = 1'b1; rxdat_data = bt(8'h99); rxdat_txnid = 3'd2; rxdat_beat_id = 2'd0;
    for (int i = 0; i < 5; i++) begin
      chk_write("t2_hold", 4'b0001, 7'h10, {bt(8'h88), bt(8'h77), bt(8'h66), bt(8'h55)});
      chk("t2_hold_done", 512'({done_a, done_b}), 512'(16'h0));
      if (i == 4) begin
        wr_rdy = 1'b1; rxdat_vld = 1'b0;
      end
      tick();
    end
    chk_done("t2", 8'h00, 8'b0000_0010);
    tick();
    chk("t2_idle_rdy", 512'(rxdat_rdy), 512'(1'b1));

    // Back-to-back A then B on entry 5, vld held high throughout.
    rxdat_txnid = 3'd5; rxdat_lineA = 1'b1; lkup_way = 4'b0010; lkup_index = 7'h2A;
    feed(8'hA0, 2'd0); feed(8'hA1, 2'd1); feed(8'hA2, 2'd2); feed(8'hA3, 2'd3);
    rxdat_lineA = 1'b0; lkup_index = 7'h2B; rxdat_data = bt(8'hB0); rxdat_beat_id = 2'd0;
    chk_write("t3a", 4'b0010, 7'h2A, {bt(8'hA3), bt(8'hA2), bt(8'hA1), bt(8'hA0)});
    tick();
    chk_done("t3a", 8'b0010_0000, 8'h00);
    chk("t3a_done_rdy", 512'(rxdat_rdy), 512'(1'b0));
    tick();
    chk("t3_gap_rdy", 512'(rxdat_rdy), 512'(1'b1));
    tick();
    feed(8'hB1, 2'd1); feed(8'hB2, 2'd2); feed(8'hB3, 2'd3);
    rxdat_vld = 1'b0;
    chk_write("t3b", 4'b0010, 7'h2B, {bt(8'hB3), bt(8'hB2), bt(8'hB1), bt(8'hB0)});
    tick();
    chk_done("t3b", 8'h00, 8'b0010_0000);
    tick();

    // Lookup values change after beat 0; write uses the sampled ones.
    rxdat_txnid = 3'd0; rxdat_lineA = 1'b1; lkup_way = 4'b1000; lkup_index = 7'h05;
    feed(8'h01, 2'd0);
    lkup_way = 4'b0001; lkup_index = 7'h7F; rxdat_txnid = 3'd4; rxdat_lineA = 1'b0;
    feed(8'h02, 2'd1); feed(8'h03, 2'd2); feed(8'h04, 2'd3);
    rxdat_vld = 1'b0;
    chk_write("t4", 4'b1000, 7'h05, {bt(8'h04), bt(8'h03), bt(8'h02), bt(8'h01)});
    tick();
    chk_done("t4", 8'b0000_0001, 8'h00);
    tick();

    // Reset after beat 2 discards the partial line.
    rxdat_txnid = 3'd6; rxdat_lineA = 1'b1; lkup_way = 4'b0010; lkup_index = 7'h44;
    feed(8'hC1, 2'd0); feed(8'hC2, 2'd1); feed(8'hC3, 2'd2);
    rxdat_vld = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_rdy", 512'(rxdat_rdy), 512'(1'b1));
    chk_done("t5_rst", 8'h00, 8'h00);
    tick();
    chk_done("t5_post", 8'h00, 8'h00);
    chk("t5_post_rdy", 512'(rxdat_rdy), 512'(1'b1));
    rxdat_txnid = 3'd7; rxdat_lineA = 1'b0; lkup_way = 4'b0100; lkup_index = 7'h33;
    feed(8'hD1, 2'd0); feed(8'hD2, 2'd1); feed(8'hD3, 2'd2); feed(8'hD4, 2'd3);
    rxdat_vld = 1'b0;
    chk_write("t5", 4'b0100, 7'h33, {bt(8'hD4), bt(8'hD3), bt(8'hD2), bt(8'hD1)});
    tick();
    chk_done("t5", 8'h00, 8'b1000_0000);
    chk("t5_err", 512'(err), 512'(1'b0));
    tick();

    // Beat ids 0,2,1,3: data still lands in arrival order.
    rxdat_txnid = 3'd2; rxdat_lineA = 1'b1; lkup_way = 4'b0001; lkup_index = 7'h01;
    feed(8'hE0, 2'd0);
    chk("t6_err_b0", 512'(err), 512'(1'b0));
    feed(8'hE1, 2'd2);
    chk("t6_err_b1", 512'(err), 512'(OrderChk));
    feed(8'hE2, 2'd1); feed(8'hE3, 2'd3);
    rxdat_vld = 1'b0;
    chk_write("t6", 4'b0001, 7'h01, {bt(8'hE3), bt(8'hE2), bt(8'hE1), bt(8'hE0)});
    tick();
    chk_done("t6", 8'b0000_0100, 8'h00);
    tick(); tick();
    chk("t6_err_sticky", 512'(err), 512'(OrderChk));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
